// File: rtl/pe_tail_fifo.sv
// Tail buffer behind the last PE: stores per-column (base, v, f) for replay into the
// first PE on the next pass, and tracks the running global best score.
module pe_tail_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic [2:0]        tail_t_i,
  input  logic [DATA_W-1:0] tail_v_i,
  input  logic [DATA_W-1:0] tail_f_i,
  input  logic [DATA_W-1:0] tail_max_i,
  input  logic              rd_en_i,
  output logic              rd_valid_o,
  output logic [2:0]        rd_t_o,
  output logic [DATA_W-1:0] rd_v_o,
  output logic [DATA_W-1:0] rd_f_o,
  output logic [DATA_W-1:0] max_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              pass_done_o,
  output logic [ADDR_W:0]   pass_len_o,
  output logic [1:0]        err_o
);

  localparam int ENTRY_W = 2 + 2 * DATA_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_data_q;

  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          count_q, count_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic signed [DATA_W-1:0] max_q, max_d, max_mid;
  logic [ADDR_W:0]          pass_cnt_q, pass_cnt_d;
  logic [ADDR_W:0]          pass_len_q, pass_len_d;
  logic                     pass_done_q, pass_done_d;
  logic [1:0]               err_q, err_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     have_data_q, have_data_d;

  logic wr_req, rd_ok, wr_acc, rd_acc, marker;

  always_comb begin
    wr_req = tail_t_i[2];
    marker = (tail_t_i == 3'b001);
    // Read acceptance looks only at pre-write occupancy: no write-to-read bypass.
    rd_ok  = rd_en_i && !empty_q;
    rd_acc = rd_ok && !clear_i;
    wr_acc = wr_req && (!full_q || rd_ok) && !clear_i;

    wr_ptr_d    = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d     = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    rd_valid_d  = rd_acc;
    have_data_d = have_data_q | rd_acc;
    err_d       = err_q | {wr_req && full_q && !rd_ok, rd_en_i && empty_q};

    max_mid = max_q;
    if ($signed(tail_max_i) > max_mid) max_mid = $signed(tail_max_i);
    if ($signed(tail_v_i) > max_mid)   max_mid = $signed(tail_v_i);
    max_d = wr_req ? max_mid : max_q;

    pass_cnt_d  = wr_acc ? pass_cnt_q + (ADDR_W+1)'(1) : pass_cnt_q;
    pass_len_d  = pass_len_q;
    pass_done_d = 1'b0;
    if (marker) begin
      pass_done_d = 1'b1;
      pass_len_d  = pass_cnt_q;
      pass_cnt_d  = '0;
    end

    // Flush for a new pass; pass_len is kept so the previous pass length stays visible.
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      max_d       = '0;
      pass_cnt_d  = '0;
      err_d       = '0;
      rd_valid_d  = 1'b0;
      pass_done_d = 1'b0;
    end

    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      max_q       <= '0;
      pass_cnt_q  <= '0;
      pass_len_q  <= '0;
      pass_done_q <= 1'b0;
      err_q       <= '0;
      rd_valid_q  <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      max_q       <= max_d;
      pass_cnt_q  <= pass_cnt_d;
      pass_len_q  <= pass_len_d;
      pass_done_q <= pass_done_d;
      err_q       <= err_d;
      rd_valid_q  <= rd_valid_d;
      have_data_q <= have_data_d;
    end
  end

  // Read-first RAM: a full-FIFO write+read at the same address returns the old entry.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= {tail_t_i[1:0], tail_v_i, tail_f_i};
    if (rd_acc) rd_data_q <= mem[rd_ptr_q];
  end

  // Replay outputs read as zero until the first read after reset.
  assign rd_t_o      = have_data_q ? {1'b1, rd_data_q[ENTRY_W-1 -: 2]} : 3'b000;
  assign rd_v_o      = have_data_q ? rd_data_q[2*DATA_W-1:DATA_W] : '0;
  assign rd_f_o      = have_data_q ? rd_data_q[DATA_W-1:0] : '0;
  assign rd_valid_o  = rd_valid_q;
  assign max_o       = max_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign pass_done_o = pass_done_q;
  assign pass_len_o  = pass_len_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pe_tail_fifo.sv
// Directed bench for pe_tail_fifo: ordering, full/empty edges, markers, max and clear.
module tb_pe_tail_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear_i = 1'b0;
  logic [2:0]        tail_t_i = 3'b000;
  logic [DATA_W-1:0] tail_v_i = '0;
  logic [DATA_W-1:0] tail_f_i = '0;
  logic [DATA_W-1:0] tail_max_i = '0;
  logic              rd_en_i = 1'b0;
  logic              rd_valid_o;
  logic [2:0]        rd_t_o;
  logic [DATA_W-1:0] rd_v_o, rd_f_o, max_o;
  logic [ADDR_W:0]   count_o, pass_len_o;
  logic              full_o, empty_o, pass_done_o;
  logic [1:0]        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  pe_tail_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .tail_t_i(tail_t_i), .tail_v_i(tail_v_i), .tail_f_i(tail_f_i), .tail_max_i(tail_max_i),
    .rd_en_i(rd_en_i), .rd_valid_o(rd_valid_o), .rd_t_o(rd_t_o), .rd_v_o(rd_v_o),
    .rd_f_o(rd_f_o), .max_o(max_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .pass_done_o(pass_done_o), .pass_len_o(pass_len_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tail_t_i = 3'b000; rd_en_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic col(input logic [2:0] t, input logic [15:0] v, input logic [15:0] f,
                     input logic [15:0] m);
    tail_t_i = t; tail_v_i = v; tail_f_i = f; tail_max_i = m;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [15:0] vv [4];
    logic [15:0] ff [4];
    vv[0] = 16'd5; vv[1] = 16'd7; vv[2] = 16'd3; vv[3] = 16'd9;
    ff[0] = 16'd1; ff[1] = 16'd2; ff[2] = 16'd3; ff[3] = 16'd4;

    // Reset values
    do_reset();
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_max", max_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rd_t", rd_t_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_pass_len", pass_len_o, 0);

    // Four columns in, four replayed out in order
    col(3'b100, 16'd5, 16'd1, 16'd0); step();
    col(3'b101, 16'd7, 16'd2, 16'd5); step();
    col(3'b110, 16'd3, 16'd3, 16'd7); step();
    col(3'b111, 16'd9, 16'd4, 16'd7); step();
    idle();
    chk("t1_count", count_o, 4);
    chk("t1_max", max_o, 9);
    rd_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_rd_valid", rd_valid_o, 1);
      chk("t1_rd_v", rd_v_o, vv[i]);
      chk("t1_rd_f", rd_f_o, ff[i]);
      chk("t1_rd_t", rd_t_o, 32'(4 + i));
    end
    rd_en_i = 1'b0;
    step();
    chk("t1_rd_valid_low", rd_valid_o, 0);
    chk("t1_rd_v_hold", rd_v_o, 9);
    chk("t1_empty", empty_o, 1);
    chk("t1_err", err_o, 0);

    // Fill to DEPTH, overflow, then full write+read
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      col({1'b1, 2'(i)}, 16'(i), 16'(i) ^ 16'h5A5A, 16'd0);
      step();
    end
    idle();
    chk("t2_full", full_o, 1);
    chk("t2_count_full", count_o, DEPTH);
    chk("t2_err_none", err_o, 0);
    col(3'b100, 16'hDEAD, 16'h0000, 16'd0); step();
    idle();
    chk("t2_overflow_err", err_o, 2'b10);
    chk("t2_overflow_count", count_o, DEPTH);
    col(3'b101, 16'hBEEF, 16'h1111, 16'd0); rd_en_i = 1'b1; step();
    idle();
    chk("t2_wr_rd_count", count_o, DEPTH);
    chk("t2_wr_rd_full", full_o, 1);
    chk("t2_wr_rd_valid", rd_valid_o, 1);
    chk("t2_wr_rd_v", rd_v_o, 0);
    chk("t2_wr_rd_f", rd_f_o, 16'h5A5A);
    chk("t2_wr_rd_t", rd_t_o, 3'b100);
    chk("t2_wr_rd_err", err_o, 2'b10);
    rd_en_i = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      step();
      chk("t2_drain_v", rd_v_o, 32'(i));
    end
    step();
    chk("t2_wrap_v", rd_v_o, 16'hBEEF);
    chk("t2_wrap_f", rd_f_o, 16'h1111);
    chk("t2_wrap_t", rd_t_o, 3'b101);
    rd_en_i = 1'b0;
    step();
    chk("t2_empty", empty_o, 1);
    chk("t2_count_zero", count_o, 0);

    // Read on empty with a same-cycle write
    do_reset();
    col(3'b100, 16'd11, 16'd12, 16'd0); rd_en_i = 1'b1; step();
    idle();
    chk("t3_rd_valid", rd_valid_o, 0);
    chk("t3_err", err_o, 2'b01);
    chk("t3_count", count_o, 1);
    chk("t3_rd_v", rd_v_o, 0);

    // End-of-target markers
    do_reset();
    col(3'b100, 16'd1, 16'd1, 16'd0); step();
    col(3'b101, 16'd2, 16'd2, 16'd0); step();
    col(3'b110, 16'd3, 16'd3, 16'd0); step();
    tail_t_i = 3'b001; step();
    chk("t4_done", pass_done_o, 1);
    chk("t4_len", pass_len_o, 3);
    chk("t4_count", count_o, 3);
    tail_t_i = 3'b001; step();
    chk("t4_done2", pass_done_o, 1);
    chk("t4_len_empty", pass_len_o, 0);
    idle(); step();
    chk("t4_done_low", pass_done_o, 0);
    chk("t4_count_kept", count_o, 3);

    // Negative scores clamp at 0, then the max positive value
    do_reset();
    col(3'b100, 16'hFFFC, 16'd0, 16'hFFFE); step();
    idle();
    chk("t5_max_neg", max_o, 0);
    col(3'b100, 16'h7FFF, 16'd0, 16'd0); step();
    idle();
    chk("t5_max_pos", max_o, 16'h7FFF);

    // Clear with simultaneous write and read
    do_reset();
    rd_en_i = 1'b1; step();
    idle();
    col(3'b100, 16'd20, 16'd0, 16'd0); step();
    col(3'b101, 16'd30, 16'd0, 16'd0); step();
    tail_t_i = 3'b001; step();
    chk("t6_len_before", pass_len_o, 2);
    col(3'b110, 16'd40, 16'd0, 16'd0); step();
    idle();
    chk("t6_err_before", err_o, 2'b01);
    chk("t6_max_before", max_o, 40);
    col(3'b100, 16'd99, 16'd0, 16'd0); rd_en_i = 1'b1; clear_i = 1'b1; step();
    idle();
    chk("t6_count", count_o, 0);
    chk("t6_max", max_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_rd_valid", rd_valid_o, 0);
    chk("t6_empty", empty_o, 1);
    chk("t6_len_kept", pass_len_o, 2);
    tail_t_i = 3'b001; step();
    idle();
    chk("t6_no_write", pass_len_o, 0);

    // Asynchronous reset between clock edges
    col(3'b100, 16'd50, 16'd0, 16'd0); step();
    idle();
    chk("t7_pre_count", count_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_count", count_o, 0);
    chk("t7_empty", empty_o, 1);
    chk("t7_max", max_o, 0);
    chk("t7_pass_len", pass_len_o, 0);
    #2 rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
